// File: rtl/carry_select_subtractor_pipe_32bits.sv
// 32-bit five-stage carry-select subtractor, D = A - B - Bin, valid/ready on both sides.
// Optional macro CSS_OVERFLOW_FLAG_EN adds the signed-overflow output OVF.
module carry_select_subtractor_pipe_32bits #(
    parameter int WIDTH = 32,
    parameter int BLOCK_AMOUNT = 5,
    parameter int BLOCKS [0:4] = '{5, 11, 17, 24, 32}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
`ifdef CSS_OVERFLOW_FLAG_EN
    output logic             OVF,
`endif
    output logic             Bout
);

    localparam int B0 = BLOCKS[0];
    localparam int B1 = BLOCKS[1];
    localparam int B2 = BLOCKS[2];
    localparam int B3 = BLOCKS[3];
    localparam int B4 = BLOCKS[BLOCK_AMOUNT-1];
    localparam int W1 = B1 - B0;
    localparam int W2 = B2 - B1;
    localparam int W3 = B3 - B2;
    localparam int W4 = B4 - B3;

    logic adv;

    logic             v0, c0;
    logic [B0-1:0]    d0;
    logic [WIDTH-1:B0] a0, nb0;
    logic             v1, c1;
    logic [B1-1:0]    d1;
    logic [WIDTH-1:B1] a1, nb1;
    logic             v2, c2;
    logic [B2-1:0]    d2;
    logic [WIDTH-1:B2] a2, nb2;
    logic             v3, c3;
    logic [B3-1:0]    d3;
    logic [WIDTH-1:B3] a3, nb3;
    logic             v4, bo4;
    logic [B4-1:0]    d4;

    logic [B0:0] s0;
    logic [W1:0] s1_c0, s1_c1, s1;
    logic [W2:0] s2_c0, s2_c1, s2;
    logic [W3:0] s3_c0, s3_c1, s3;
    logic [W4:0] s4_c0, s4_c1, s4;

    // The whole pipe moves as one; a held result blocks everything behind it.
    assign adv       = !v4 || out_ready;
    assign in_ready  = adv;
    assign out_valid = v4;
    assign D         = d4;
    assign Bout      = bo4;

    // Block 0 ripples directly; subtraction is A + ~B + !Bin.
    assign s0 = {1'b0, A[B0-1:0]} + {1'b0, ~B[B0-1:0]}
              + {{B0{1'b0}}, ~Bin};

    // Upper blocks: both carry hypotheses, picked by the previous stage's carry.
    assign s1_c0 = {1'b0, a0[B1-1:B0]} + {1'b0, nb0[B1-1:B0]};
    assign s1_c1 = {1'b0, a0[B1-1:B0]} + {1'b0, nb0[B1-1:B0]}
                 + {{W1{1'b0}}, 1'b1};
    assign s1    = c0 ? s1_c1 : s1_c0;

    assign s2_c0 = {1'b0, a1[B2-1:B1]} + {1'b0, nb1[B2-1:B1]};
    assign s2_c1 = {1'b0, a1[B2-1:B1]} + {1'b0, nb1[B2-1:B1]}
                 + {{W2{1'b0}}, 1'b1};
    assign s2    = c1 ? s2_c1 : s2_c0;

    assign s3_c0 = {1'b0, a2[B3-1:B2]} + {1'b0, nb2[B3-1:B2]};
    assign s3_c1 = {1'b0, a2[B3-1:B2]} + {1'b0, nb2[B3-1:B2]}
                 + {{W3{1'b0}}, 1'b1};
    assign s3    = c2 ? s3_c1 : s3_c0;

    assign s4_c0 = {1'b0, a3[B4-1:B3]} + {1'b0, nb3[B4-1:B3]};
    assign s4_c1 = {1'b0, a3[B4-1:B3]} + {1'b0, nb3[B4-1:B3]}
                 + {{W4{1'b0}}, 1'b1};
    assign s4    = c3 ? s4_c1 : s4_c0;

    // Stage 0: capture block 0 result and the untouched upper operand slices.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0  <= 1'b0;
            c0  <= 1'b0;
            d0  <= '0;
            a0  <= '0;
            nb0 <= '0;
        end else if (adv) begin
            v0  <= in_valid;
            c0  <= s0[B0];
            d0  <= s0[B0-1:0];
            a0  <= A[WIDTH-1:B0];
            nb0 <= ~B[WIDTH-1:B0];
        end
    end

    // Stage 1: append block 1 to the partial difference.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            c1  <= 1'b0;
            d1  <= '0;
            a1  <= '0;
            nb1 <= '0;
        end else if (adv) begin
            v1  <= v0;
            c1  <= s1[W1];
            d1  <= {s1[W1-1:0], d0};
            a1  <= a0[WIDTH-1:B1];
            nb1 <= nb0[WIDTH-1:B1];
        end
    end

    // Stage 2: append block 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2  <= 1'b0;
            c2  <= 1'b0;
            d2  <= '0;
            a2  <= '0;
            nb2 <= '0;
        end else if (adv) begin
            v2  <= v1;
            c2  <= s2[W2];
            d2  <= {s2[W2-1:0], d1};
            a2  <= a1[WIDTH-1:B2];
            nb2 <= nb1[WIDTH-1:B2];
        end
    end

    // Stage 3: append block 3; the top slice keeps the operand sign bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3  <= 1'b0;
            c3  <= 1'b0;
            d3  <= '0;
            a3  <= '0;
            nb3 <= '0;
        end else if (adv) begin
            v3  <= v2;
            c3  <= s3[W3];
            d3  <= {s3[W3-1:0], d2};
            a3  <= a2[WIDTH-1:B3];
            nb3 <= nb2[WIDTH-1:B3];
        end
    end

    // Stage 4: final block; borrow is the inverted carry so reset reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            v4  <= 1'b0;
            bo4 <= 1'b0;
            d4  <= '0;
        end else if (adv) begin
            v4  <= v3;
            bo4 <= ~s4[W4];
            d4  <= {s4[W4-1:0], d3};
        end
    end

`ifdef CSS_OVERFLOW_FLAG_EN
    logic ovf4;
    assign OVF = ovf4;

    // Signs differ when A's sign equals ~B's sign; overflow if D's sign flips from A.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf4 <= 1'b0;
        end else if (adv) begin
            ovf4 <= (a3[WIDTH-1] == nb3[WIDTH-1])
                 && (s4[W4-1] != a3[WIDTH-1]);
        end
    end
`endif

endmodule

// File: tb/tb_carry_select_subtractor_pipe_32bits.sv
// Directed-vector bench for the pipelined carry-select subtractor.
// Covers latency, wrap-around, streaming, stall/drain and mid-flight reset.
module tb_carry_select_subtractor_pipe_32bits;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] D;
    logic        Bout;
`ifdef CSS_OVERFLOW_FLAG_EN
    logic        OVF;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] d;
        logic        bout;
        logic        ovf;
    } vec_t;

    vec_t vt [11];
    logic [32:0] expq [$];

    carry_select_subtractor_pipe_32bits dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
`ifdef CSS_OVERFLOW_FLAG_EN
        .OVF       (OVF),
`endif
        .Bout      (Bout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [32:0] act,
                       input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic bin);
        return {1'b0, a} - {1'b0, b} - {32'd0, bin};
    endfunction

    task automatic run_one(input vec_t v, input int idx);
        int cyc;
        A = v.a;
        B = v.b;
        Bin = v.bin;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!out_valid) begin
            chk($sformatf("vec%0d timeout", idx), {32'd0, out_valid}, 33'd1);
        end else begin
            chk($sformatf("vec%0d latency", idx), 33'(cyc), 33'd5);
            chk($sformatf("vec%0d D", idx), {1'b0, D}, {1'b0, v.d});
            chk($sformatf("vec%0d Bout", idx), {32'd0, Bout}, {32'd0, v.bout});
`ifdef CSS_OVERFLOW_FLAG_EN
            chk($sformatf("vec%0d OVF", idx), {32'd0, OVF}, {32'd0, v.ovf});
`endif
        end
        @(negedge clk);
    endtask

    task automatic drain(input string nm, input int n);
        int got;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk({nm, " extra"}, {32'd0, out_valid}, 33'd0);
                end else begin
                    chk($sformatf("%s res%0d", nm, got), {Bout, D},
                        expq.pop_front());
                    got++;
                end
            end
            @(negedge clk);
        end
        chk({nm, " count"}, 33'(got), 33'(n));
    endtask

    initial begin
        int first;
        int last;
        int got;
        int sent;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rbin;
        logic        seen;

        vt[0]  = '{32'd100, 32'd58, 1'b0, 32'd42, 1'b0, 1'b0};
        vt[1]  = '{32'd0, 32'd1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vt[2]  = '{32'h1F, 32'h1F, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vt[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b0, 1'b0};
        vt[4]  = '{32'd0, 32'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vt[5]  = '{32'h12345678, 32'h11111111, 1'b0, 32'h01234567, 1'b0, 1'b0};
        vt[6]  = '{32'h80000000, 32'd1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
        vt[7]  = '{32'h00010000, 32'd1, 1'b1, 32'h0000FFFE, 1'b0, 1'b0};
        vt[8]  = '{32'd1, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0};
        vt[9]  = '{32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0};
        vt[10] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst out_valid", {32'd0, out_valid}, 33'd0);
        chk("rst D", {1'b0, D}, 33'd0);
        chk("rst Bout", {32'd0, Bout}, 33'd0);
        chk("rst in_ready", {32'd0, in_ready}, 33'd1);

        for (int i = 0; i < 11; i++) run_one(vt[i], i);

        // Back-to-back random stream with out_ready high.
        first = -1;
        last = -1;
        got = 0;
        sent = 0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("stream extra", {32'd0, out_valid}, 33'd0);
                end else begin
                    chk($sformatf("stream res%0d", got), {Bout, D},
                        expq.pop_front());
                    if (first < 0) first = c;
                    last = c;
                    got++;
                end
            end
            if (sent < 8) begin
                ra = $urandom;
                rb = $urandom;
                rbin = 1'($urandom_range(0, 1));
                A = ra;
                B = rb;
                Bin = rbin;
                in_valid = 1'b1;
                chk("stream in_ready", {32'd0, in_ready}, 33'd1);
                expq.push_back(model(ra, rb, rbin));
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("stream count", 33'(got), 33'd8);
        chk("stream span", 33'(last - first), 33'd7);

        // Fill the pipe against a stalled sink, then drain.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ra = $urandom;
            rb = $urandom;
            rbin = 1'(i & 1);
            A = ra;
            B = rb;
            Bin = rbin;
            in_valid = 1'b1;
            chk($sformatf("fill in_ready%0d", i), {32'd0, in_ready}, 33'd1);
            expq.push_back(model(ra, rb, rbin));
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall in_ready%0d", i), {32'd0, in_ready}, 33'd0);
            chk($sformatf("stall valid%0d", i), {32'd0, out_valid}, 33'd1);
            chk($sformatf("stall hold%0d", i), {Bout, D}, expq[0]);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain("drain", 5);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            A = 32'(i + 7);
            B = 32'd3;
            Bin = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst out_valid", {32'd0, out_valid}, 33'd0);
        chk("midrst D", {1'b0, D}, 33'd0);
        chk("midrst in_ready", {32'd0, in_ready}, 33'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen = seen | out_valid;
            @(negedge clk);
        end
        chk("midrst ghost", {32'd0, seen}, 33'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/carry_select_subtractor_pipe_32bits.md
Name: carry_select_subtractor_pipe_32bits

Overview:
- 32-bit pipelined subtractor: computes D = A - B - Bin and borrow out.
- Uses the team's non-uniform carry-select block boundaries {5, 11, 17, 24, 32}, with one pipeline register after each block.
- Valid/ready handshake on both sides; serves as the subtract datapath next to the carry-select adders in the arithmetic cluster.

Parameters:
- WIDTH, 32, operand width; only 32 is supported.
- BLOCK_AMOUNT, 5, number of blocks and pipeline stages.
- BLOCKS[0:4], '{5, 11, 17, 24, 32}, cumulative upper boundary of each block; block k spans bits BLOCKS[k]-1 : BLOCKS[k-1], and block 0 spans 4:0.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  stage 0 can accept.
- A  in  32  minuend, unsigned.
- B  in  32  subtrahend, unsigned.
- Bin  in  1  borrow in.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- D  out  32  difference, modulo 2^32.
- Bout  out  1  borrow out; 1 iff A < B + Bin as unsigned values.

Behaviour:
- Arithmetic: D = A + ~B + !Bin, taken mod 2^32. Bout is the inverse of the final carry.
- Stage k (k = 0..4):
  - Stage 0 computes block 0 directly with ripple logic.
  - Stages 1..4 each pre-compute their block twice, with carry 0 and with carry 1, then select using the registered carry from stage k-1.
  - Each stage registers: its valid bit, the selected block result, the carry out, the remaining upper operand slices (A and ~B), and the lower D slices produced so far.
- Latency: exactly 5 cycles from an accepted input (in_valid && in_ready at edge t) to out_valid at edge t+5, provided there is no stall.
- Throughput: one result per cycle.
- Advance: advance = !out_valid || out_ready.
  - All five stages shift together when advance = 1, and hold all state when advance = 0.
  - in_ready = advance, combinationally.
- Bubbles: if in_valid = 0 while advance = 1, a bubble (valid = 0) enters stage 0. Bubbles propagate and never produce out_valid.
- Output stability: while out_valid = 1 and out_ready = 0, D and Bout hold stable.
- Input rules:
  - in_valid must not depend on in_ready.
  - A, B and Bin are sampled only on an accepting edge.
- Simultaneous events: accept and emit on the same edge is legal. A full pipeline with out_ready = 1 sustains 1/cycle.
- Reset:
  - All stage valid bits = 0, out_valid = 0, D = 0, Bout = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards every in-flight result; no partial output.
- Wrap-around: 0 - 1 gives D = 32'hFFFFFFFF, Bout = 1. There is no saturation.
- Ordering: results emerge in acceptance order; there is no reordering and no drop while out_ready is low.

Optional Feature:
- Macro: CSS_OVERFLOW_FLAG_EN.
- When defined:
  - Adds output port OVF (out, 1): signed overflow of A - B - Bin.
  - OVF = (A[31] != B[31]) && (D[31] != A[31]).
  - It is carried through the pipeline, aligned with D, reset to 0, and held under stall.
- When undefined: port OVF and its pipeline bits are absent; all other behaviour is identical.

Test Plan:
- After rst, A=32'd100, B=32'd58, Bin=0, out_ready=1 -> out_valid exactly 5 cycles later; D=32'd42, Bout=0.
- A=0, B=1, Bin=0 -> D=32'hFFFFFFFF, Bout=1. Also A=32'h0000001F, B=32'h0000001F, Bin=1 -> D=32'hFFFFFFFF, Bout=1; this exercises borrow across every block boundary.
- Back-to-back 8 random pairs with out_ready=1 -> 8 consecutive out_valid cycles, in order, matching the reference model.
- Full pipeline with out_ready held 0 for 4 cycles -> in_ready=0 and D/Bout stable. On release, the results drain in order with none lost or duplicated.
- Assert rst for 1 cycle while 3 operations are in flight -> out_valid=0 and D=0 next cycle, and none of the 3 results ever appear.
- With CSS_OVERFLOW_FLAG_EN: A=32'h7FFFFFFF, B=32'hFFFFFFFF, Bin=0 -> D=32'h80000000, OVF=1. A=32'h80000000, B=1 -> D=32'h7FFFFFFF, OVF=1. A=5, B=3 -> OVF=0.
